// File: rtl/ara_perf_pkg.sv
// Shared types and register map for the Ara performance-counter controller.
package ara_perf_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [2:0] RegRuntime = 3'd0;
  localparam logic [2:0] RegDcache  = 3'd1;
  localparam logic [2:0] RegIcache  = 3'd2;
  localparam logic [2:0] RegSbFull  = 3'd3;
  localparam logic [2:0] RegStatus  = 3'd4;

  // Snapshot values zero-extended to the 64-bit read-port width.
  typedef struct packed {
    logic [63:0] runtime;
    logic [63:0] dcache;
    logic [63:0] icache;
    logic [63:0] sb_full;
  } cnt_vec_t;

endpackage

// File: rtl/ara_sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
module ara_sat_counter #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o,
  output logic             ovf_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      // At all-ones the count holds and the attempt is remembered.
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/ara_perf_cnt_ctrl.sv
// Kernel runtime / CVA6 stall measurement: arms on sw enable, starts on first
// vector dispatch, snapshots all counters when the clusters drain.
module ara_perf_cnt_ctrl
  import ara_perf_pkg::*;
#(
  parameter int unsigned NrClusters = 4,
  parameter int unsigned CntWidth   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sw_en_i,
  input  logic                  clear_i,
  input  logic                  acc_req_valid_i,
  input  logic [NrClusters-1:0] cluster_idle_i,
  input  logic                  dcache_miss_i,
  input  logic                  icache_miss_i,
  input  logic                  sb_full_i,
  input  logic                  rd_req_i,
  input  logic [2:0]            rd_addr_i,
  output logic                  rd_valid_o,
  output logic [63:0]           rd_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e state_q, state_d;

  logic quiet, count_en, snap_take;
  logic [3:0] ev, ovf;
  logic [CntWidth-1:0] cnt    [4];
  logic [CntWidth-1:0] snap_q [4];
  logic [CntWidth-1:0] snap_d [4];
  cnt_vec_t snap_vec;

  logic        rd_valid_q, rd_valid_d;
  logic [63:0] rd_data_q, rd_data_d;

  assign quiet     = (&cluster_idle_i) & ~acc_req_valid_i;
  assign count_en  = (state_q == StRun) || (state_q == StPause);
  assign snap_take = (state_q == StRun) && quiet;

  // Index 0 is the runtime counter, which counts every enabled cycle.
  assign ev = {sb_full_i, icache_miss_i, dcache_miss_i, 1'b1};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    ara_sat_counter #(.Width(CntWidth)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (count_en & ev[gi]),
      .clr_i  (clear_i),
      .cnt_o  (cnt[gi]),
      .ovf_o  (ovf[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (sw_en_i && acc_req_valid_i) state_d = StRun;
        StRun:   if (quiet) state_d = sw_en_i ? StPause : StDone;
        // A fresh dispatch outranks a simultaneous disarm.
        StPause: if (acc_req_valid_i) state_d = StRun;
                 else if (!sw_en_i)   state_d = StDone;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      snap_d[i] = snap_q[i];
      if (clear_i)        snap_d[i] = '0;
      else if (snap_take) snap_d[i] = cnt[i];
    end
  end

  assign snap_vec.runtime = 64'(snap_q[0]);
  assign snap_vec.dcache  = 64'(snap_q[1]);
  assign snap_vec.icache  = 64'(snap_q[2]);
  assign snap_vec.sb_full = 64'(snap_q[3]);

  // Reads sample snap_q, so a read racing a snapshot sees the older value.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (clear_i) begin
      rd_data_d = '0;
    end else if (rd_req_i) begin
      rd_valid_d = 1'b1;
      case (rd_addr_i)
        RegRuntime: rd_data_d = snap_vec.runtime;
        RegDcache:  rd_data_d = snap_vec.dcache;
        RegIcache:  rd_data_d = snap_vec.icache;
        RegSbFull:  rd_data_d = snap_vec.sb_full;
        RegStatus:  rd_data_d = 64'({ovf, state_q});
        default:    rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign busy_o     = count_en;
  assign done_o     = (state_q == StDone);

endmodule

// File: doc/ara_perf_cnt_ctrl.md
Name: ara_perf_cnt_ctrl

Overview:
- Measurement controller for vector-kernel runtime and CVA6 stall events in the multi-cluster Ara SoC.
- Arms under a software enable and starts on the first dispatched vector instruction.
- Stops when every cluster is idle and no dispatch is pending, then snapshots all counters into read-only buffers.
- Sits beside the Ara cluster in ara_system. Replaces ad-hoc hierarchical-probe counters with a synthesizable block that has a register read port.

Parameters:
- NrClusters, 4, number of Ara clusters; width of the idle vector.
- CntWidth, 64, width of every counter and snapshot buffer; 8 <= CntWidth <= 64.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- sw_en_i  in  1  software measurement enable (level).
- clear_i  in  1  synchronous clear pulse; zeroes all state.
- acc_req_valid_i  in  1  vector instruction dispatch valid from CVA6.
- cluster_idle_i  in  NrClusters  per-cluster ara_idle.
- dcache_miss_i  in  1  L1 D$ miss event.
- icache_miss_i  in  1  L1 I$ miss event.
- sb_full_i  in  1  scoreboard-full event.
- rd_req_i  in  1  register read request, one cycle.
- rd_addr_i  in  3  register index.
- rd_valid_o  out  1  read data valid.
- rd_data_o  out  64  read data, zero-extended from CntWidth.
- busy_o  out  1  state is RUN or PAUSE.
- done_o  out  1  state is DONE.

Behaviour:
- Reset (async) and clear_i (sync, highest priority in any state):
  - State goes to IDLE.
  - All counters, buffers, overflow flags and rd_valid_o go to 0; rd_data_o goes to 0.
  - busy_o = 0 and done_o = 0.
- Definitions:
  - all_idle = AND of cluster_idle_i.
  - quiet = all_idle & !acc_req_valid_i.
- FSM (registered state):
  - IDLE: if sw_en_i & acc_req_valid_i, go to RUN. No counting.
  - RUN: if quiet, snapshot (buf <= cnt_q) and go to PAUSE when sw_en_i = 1, or to DONE when sw_en_i = 0.
  - PAUSE: if acc_req_valid_i, go to RUN; this wins over a simultaneous sw_en_i = 0. Otherwise, if !sw_en_i, go to DONE with no new snapshot.
  - DONE: holds. Only clear_i leaves DONE. A new acc_req_valid_i is ignored.
- Counting:
  - Counting is enabled in RUN and PAUSE.
  - The runtime counter increments every enabled cycle.
  - The dcache, icache and sb_full counters increment on enabled cycles in which their event input is 1.
  - The first count occurs in the cycle after the dispatch that left IDLE. At the snapshot the runtime value equals the number of cycles spent in RUN/PAUSE before the snapshot cycle.
- Snapshot:
  - Captures cnt_q, i.e. it excludes the snapshot cycle's own increment.
  - Re-triggers on every RUN->quiet transition, so the last snapshot wins.
- Saturation:
  - Counters saturate at all-ones and never wrap.
  - Each counter has a sticky overflow flag, set on the cycle an increment is attempted at all-ones.
  - Flags clear only on reset or clear_i.
- Read port:
  - rd_valid_o pulses exactly one cycle after rd_req_i.
  - rd_data_o is registered and taken from the buffer value at the request cycle.
  - A read in the same cycle as a snapshot returns the pre-snapshot value.
  - rd_data_o holds its value between reads.
  - Address map:
    - 0: runtime buffer.
    - 1: dcache buffer.
    - 2: icache buffer.
    - 3: sb_full buffer.
    - 4: status, with [1:0] state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3), [5:2] overflow flags (runtime, dcache, icache, sb_full), rest 0.
    - 5-7: read as 0.
  - Back-to-back requests are accepted every cycle.
- Simultaneous events:
  - clear_i beats everything else.
  - In RUN, quiet cannot coincide with a dispatch, by definition.
- sw_en_i deasserted in RUN does not stop counting. The block keeps counting until quiet.

Decomposition:
- Package ara_perf_pkg contains:
  - the state enum;
  - register index localparams (RegRuntime=0, RegDcache=1, RegIcache=2, RegSbFull=3, RegStatus=4);
  - the counter-vector struct type.
- Sub-module ara_sat_counter (parameter Width; ports en_i, clr_i, cnt_o, ovf_o):
  - Saturating counter with a sticky overflow flag.
  - Instantiated four times.
- FSM, snapshot registers and the read mux live in the top module.

Test Plan:
- Basic measurement, NrClusters=4:
  - Stimulus: sw_en=1; dispatch pulse at cycle 10; idle=4'b0000 over cycles 11-30; idle=4'b1111 from cycle 31; sw_en=0 at cycle 40.
  - Required: read addr0 = 20; state PAUSE at cycle 32; DONE at cycle 41; done_o=1.
- Event counts:
  - Stimulus: same window as the basic measurement; dcache_miss high for 5 cycles inside RUN and 3 cycles while in IDLE.
  - Required: addr1 = 5; addr2 = 0.
- Re-dispatch from PAUSE:
  - Stimulus: first snapshot runtime = 20; dispatch at cycle 35; idle low for 10 cycles; then quiet.
  - Required: addr0 = 34 (the count continues through the gap); dispatch coinciding with sw_en=0 in PAUSE gives state RUN.
- Saturation with CntWidth=8:
  - Stimulus: run for 300 cycles.
  - Required: addr0 = 255; status bit2 = 1; clear_i gives addr0 = 0, status = 0, state IDLE.
- Read/snapshot race and reset:
  - Stimulus: rd_req on addr0 in the snapshot cycle; separately, rst_ni low mid-RUN.
  - Required: the race read returns the old buffer value, with rd_valid_o one cycle later; the reset gives all outputs 0 and state IDLE immediately (async).
